// File: rtl/dna_pkg.sv
// Shared definitions for the device-DNA controller: FSM encodings, code-word
// layout constants and the word-select helper.
package dna_pkg;

  // Gray-style walk matching the reader's own sequencer.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_ARM   = 3'b001,
    ST_WAIT  = 3'b011,
    ST_CHECK = 3'b010,
    ST_CMP   = 3'b110,
    ST_READY = 3'b111,
    ST_FAIL  = 3'b101
  } dna_state_t;

  localparam int DNA_RAW_LSB  = 7;
  localparam int DNA_RAW_BITS = 57;
  localparam int DNA_CNT_LSB  = 1;
  localparam int DNA_CNT_BITS = 6;
  localparam int DNA_WORDS    = 4;

  function automatic logic [15:0] dna_word(input logic [63:0] code,
                                           input logic [$clog2(DNA_WORDS)-1:0] w);
    logic [15:0] word;
    case (w)
      2'd0:    word = code[15:0];
      2'd1:    word = code[31:16];
      2'd2:    word = code[47:32];
      default: word = code[63:48];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/dna_rr_arb.sv
// Two-way round-robin arbiter. The grant is combinational; only the
// last-grant pointer is stored, and it moves only when a grant is issued.
module dna_rr_arb (
  input  logic       CLK4,
  input  logic       RSTn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_one;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_one ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer starts on requester 1 so requester 0 wins the first contention.
  always_ff @(posedge CLK4 or negedge RSTn) begin
    if (!RSTn) begin
      last_one <= 1'b1;
    end else if (gnt[0]) begin
      last_one <= 1'b0;
    end else if (gnt[1]) begin
      last_one <= 1'b1;
    end
  end

endmodule

// File: rtl/dna_arb.sv
// Sequences the device-DNA reader, re-verifies the code's check bits serially
// and then shares 16-bit word reads between two requesters.
module dna_arb #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        CLK4,
  input  logic        RSTn,
  input  logic        START,
  output logic        DNA_ATV,
  input  logic        DNA_VLD,
  input  logic [63:0] DNA_IN,
  input  logic [1:0]  REQ,
  input  logic [3:0]  ADDR,
  output logic [1:0]  GNT,
  output logic [15:0] RDATA,
  output logic        READY,
  output logic        FAIL
);

  import dna_pkg::*;

  localparam logic [15:0] TMO      = 16'(TIMEOUT_CYC);
  localparam logic [5:0]  IDX_LAST = 6'(DNA_RAW_BITS - 1);

  dna_state_t              state, state_nxt;
  logic [15:0]             timer, timer_inc;
  logic [63:0]             code;
  logic [5:0]              idx;
  logic [DNA_CNT_BITS-1:0] ones;
  logic                    par;
  logic [DNA_RAW_BITS-1:0] raw;
  logic                    pass;
  logic                    arb_en;
  logic [1:0]              arb_gnt;

  assign timer_inc = timer + 16'd1;
  assign raw       = code[DNA_RAW_LSB +: DNA_RAW_BITS];
  assign pass      = (ones == code[DNA_CNT_LSB +: DNA_CNT_BITS]) && ((par ^ (^ones)) == code[0]);
  assign arb_en    = (state == ST_READY) && !START;

  always_ff @(posedge CLK4 or negedge RSTn) begin
    if (!RSTn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (START) state_nxt = ST_ARM;
      ST_ARM:   state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (DNA_VLD)               state_nxt = ST_CHECK;
        else if (timer_inc == TMO) state_nxt = ST_FAIL;
      end
      ST_CHECK: if (idx == IDX_LAST) state_nxt = ST_CMP;
      ST_CMP:   state_nxt = pass ? ST_READY : ST_FAIL;
      ST_READY: if (START) state_nxt = ST_ARM;
      ST_FAIL:  if (START) state_nxt = ST_ARM;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The reader stays armed from WAIT through READY; ARM and FAIL hold it in reset.
  always_comb begin
    DNA_ATV = 1'b0;
    READY   = 1'b0;
    FAIL    = 1'b0;
    case (state)
      ST_WAIT, ST_CHECK, ST_CMP: DNA_ATV = 1'b1;
      ST_READY: begin
        DNA_ATV = 1'b1;
        READY   = 1'b1;
      end
      ST_FAIL:  FAIL = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge CLK4 or negedge RSTn) begin
    if (!RSTn) begin
      timer <= '0;
      code  <= '0;
      idx   <= '0;
      ones  <= '0;
      par   <= 1'b0;
    end else begin
      case (state)
        ST_ARM: timer <= '0;
        ST_WAIT: begin
          timer <= timer_inc;
          if (DNA_VLD) begin
            code <= DNA_IN;
            idx  <= '0;
            ones <= '0;
            par  <= 1'b0;
          end
        end
        ST_CHECK: begin
          idx <= idx + 6'd1;
          if (raw[idx]) begin
            ones <= ones + 6'd1;
            par  <= ~par;
          end
        end
        default: ;
      endcase
    end
  end

  dna_rr_arb u_rr (
    .CLK4 (CLK4),
    .RSTn (RSTn),
    .en   (arb_en),
    .req  (REQ),
    .gnt  (arb_gnt)
  );

  // RDATA only moves on a grant so consumers can sample it lazily.
  always_ff @(posedge CLK4 or negedge RSTn) begin
    if (!RSTn) begin
      GNT   <= 2'b00;
      RDATA <= '0;
    end else begin
      GNT <= arb_gnt;
      if (arb_gnt[0]) begin
        RDATA <= dna_word(code, ADDR[1:0]);
      end else if (arb_gnt[1]) begin
        RDATA <= dna_word(code, ADDR[3:2]);
      end
    end
  end

endmodule

// File: tb/tb_dna_arb.sv
// Directed self-checking bench for dna_arb: read/verify, bad parity, timeout,
// arbitration, re-read and asynchronous reset during CHECK.
module tb_dna_arb;

  localparam logic [63:0] CODE_ONE  = 64'h0000_0000_0000_0082;
  localparam logic [63:0] CODE_BAD  = 64'h0000_0000_0000_0083;
  localparam logic [63:0] CODE_MAIN = 64'h8001_0000_0000_0107;

  logic        CLK4    = 1'b0;
  logic        RSTn    = 1'b0;
  logic        START   = 1'b0;
  logic        DNA_VLD = 1'b0;
  logic [63:0] DNA_IN  = '0;
  logic [1:0]  REQ     = '0;
  logic [3:0]  ADDR    = '0;
  logic        DNA_ATV, READY, FAIL;
  logic [1:0]  GNT;
  logic [15:0] RDATA;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK4 = ~CLK4;

  dna_arb #(.TIMEOUT_CYC(100)) dut (
    .CLK4    (CLK4),
    .RSTn    (RSTn),
    .START   (START),
    .DNA_ATV (DNA_ATV),
    .DNA_VLD (DNA_VLD),
    .DNA_IN  (DNA_IN),
    .REQ     (REQ),
    .ADDR    (ADDR),
    .GNT     (GNT),
    .RDATA   (RDATA),
    .READY   (READY),
    .FAIL    (FAIL)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, return at the next falling edge.
  task automatic applyStimulus(input logic st, input logic vld, input logic [63:0] din,
                               input logic [1:0] req, input logic [3:0] addr);
    START   = st;
    DNA_VLD = vld;
    DNA_IN  = din;
    REQ     = req;
    ADDR    = addr;
    @(negedge CLK4);
  endtask

  // START, ARM, optional idle WAIT cycles, VLD edge k, then edges k+1..k+58.
  task automatic readCode(input logic [63:0] din, input int waitCycles);
    int early;
    applyStimulus(1'b1, 1'b0, 64'h0, 2'b00, 4'h0);
    checkOutput("arm_atv", 64'(DNA_ATV), 64'd0);
    checkOutput("arm_ready", 64'(READY), 64'd0);
    checkOutput("arm_fail", 64'(FAIL), 64'd0);
    applyStimulus(1'b0, 1'b0, 64'h0, 2'b00, 4'h0);
    checkOutput("wait_atv", 64'(DNA_ATV), 64'd1);
    if (waitCycles > 0) begin
      early = 0;
      for (int i = 0; i < waitCycles; i++) begin
        applyStimulus(1'b0, 1'b0, 64'h0, 2'b00, 4'h0);
        if (FAIL) early++;
      end
      checkOutput("wait_no_timeout", 64'(early), 64'd0);
    end
    applyStimulus(1'b0, 1'b1, din, 2'b00, 4'h0);
    checkOutput("vld_fail", 64'(FAIL), 64'd0);
    checkOutput("vld_atv", 64'(DNA_ATV), 64'd1);
    early = 0;
    for (int i = 0; i < 57; i++) begin
      applyStimulus(1'b0, 1'b0, 64'h0, 2'b00, 4'h0);
      if (READY || FAIL) early++;
    end
    checkOutput("check_quiet", 64'(early), 64'd0);
    applyStimulus(1'b0, 1'b0, 64'h0, 2'b00, 4'h0);
  endtask

  logic [1:0]  expGnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [15:0] expData[4] = '{16'h0107, 16'h8001, 16'h0107, 16'h8001};

  initial begin
    int cnt;

    // Reset state
    @(negedge CLK4);
    @(negedge CLK4);
    checkOutput("rst_atv", 64'(DNA_ATV), 64'd0);
    checkOutput("rst_ready", 64'(READY), 64'd0);
    checkOutput("rst_fail", 64'(FAIL), 64'd0);
    checkOutput("rst_gnt", 64'(GNT), 64'd0);
    checkOutput("rst_rdata", 64'(RDATA), 64'd0);
    RSTn = 1'b1;
    @(negedge CLK4);

    // Valid single-bit code
    readCode(CODE_ONE, 0);
    checkOutput("one_ready", 64'(READY), 64'd1);
    checkOutput("one_fail", 64'(FAIL), 64'd0);
    checkOutput("one_atv", 64'(DNA_ATV), 64'd1);

    // Bad parity, then no grants while failed
    readCode(CODE_BAD, 0);
    checkOutput("bad_fail", 64'(FAIL), 64'd1);
    checkOutput("bad_ready", 64'(READY), 64'd0);
    checkOutput("bad_atv", 64'(DNA_ATV), 64'd0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 64'h0, 2'b11, 4'h0);
      if (GNT != 2'b00) cnt++;
    end
    checkOutput("bad_no_gnt", 64'(cnt), 64'd0);

    // Contention with ADDR = word 0 for requester 0, word 3 for requester 1
    readCode(CODE_MAIN, 0);
    checkOutput("main_ready", 64'(READY), 64'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 64'h0, 2'b11, 4'b1100);
      checkOutput($sformatf("rr_gnt%0d", i), 64'(GNT), 64'(expGnt[i]));
      checkOutput($sformatf("rr_data%0d", i), 64'(RDATA), 64'(expData[i]));
    end
    applyStimulus(1'b0, 1'b0, 64'h0, 2'b01, 4'b0011);
    checkOutput("solo_gnt_a", 64'(GNT), 64'd1);
    checkOutput("solo_data_a", 64'(RDATA), 64'h8001);
    applyStimulus(1'b0, 1'b0, 64'h0, 2'b01, 4'b0000);
    checkOutput("solo_gnt_b", 64'(GNT), 64'd1);
    checkOutput("solo_data_b", 64'(RDATA), 64'h0107);
    applyStimulus(1'b0, 1'b0, 64'h0, 2'b00, 4'b0011);
    checkOutput("idle_gnt", 64'(GNT), 64'd0);
    checkOutput("idle_hold", 64'(RDATA), 64'h0107);

    // Re-read from READY: START beats REQ
    applyStimulus(1'b1, 1'b0, 64'h0, 2'b01, 4'h0);
    checkOutput("reread_gnt", 64'(GNT), 64'd0);
    checkOutput("reread_ready", 64'(READY), 64'd0);
    checkOutput("reread_atv", 64'(DNA_ATV), 64'd0);
    applyStimulus(1'b0, 1'b0, 64'h0, 2'b01, 4'h0);
    checkOutput("reread_atv_up", 64'(DNA_ATV), 64'd1);

    // Timeout: WAIT entered at the previous edge, FAIL at the 100th edge after it
    cnt = 0;
    for (int i = 0; i < 99; i++) begin
      applyStimulus(1'b0, 1'b0, 64'h0, 2'b01, 4'h0);
      if (FAIL || GNT != 2'b00) cnt++;
    end
    checkOutput("tmo_early", 64'(cnt), 64'd0);
    applyStimulus(1'b0, 1'b0, 64'h0, 2'b00, 4'h0);
    checkOutput("tmo_fail", 64'(FAIL), 64'd1);
    checkOutput("tmo_atv", 64'(DNA_ATV), 64'd0);

    // VLD on the same edge the timer expires wins
    readCode(CODE_MAIN, 99);
    checkOutput("edge_ready", 64'(READY), 64'd1);
    checkOutput("edge_fail", 64'(FAIL), 64'd0);

    // Asynchronous reset at CHECK idx 30
    applyStimulus(1'b1, 1'b0, 64'h0, 2'b00, 4'h0);
    applyStimulus(1'b0, 1'b0, 64'h0, 2'b00, 4'h0);
    applyStimulus(1'b0, 1'b1, CODE_MAIN, 2'b00, 4'h0);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, 64'h0, 2'b00, 4'h0);
    checkOutput("mid_atv", 64'(DNA_ATV), 64'd1);
    RSTn = 1'b0;
    #1;
    checkOutput("arst_atv", 64'(DNA_ATV), 64'd0);
    checkOutput("arst_ready", 64'(READY), 64'd0);
    checkOutput("arst_fail", 64'(FAIL), 64'd0);
    checkOutput("arst_gnt", 64'(GNT), 64'd0);
    checkOutput("arst_rdata", 64'(RDATA), 64'd0);
    @(negedge CLK4);
    RSTn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 64'h0, 2'b11, 4'b1100);
      if (GNT != 2'b00 || READY || DNA_ATV) cnt++;
    end
    checkOutput("post_rst_idle", 64'(cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
